// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg
// Shared definitions for the program sequencer: FSM state encoding, the NOP
// opcode, the SPI word size and the opcode/operand field positions within
// a stored program word.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_GAP,
    S_HALT
  } state_t;

  localparam logic [3:0] NOP_OPCODE    = 4'h0;
  localparam int         SPI_WORD_BITS = 12;

  localparam int OPCODE_MSB  = 11;
  localparam int OPCODE_LSB  = 8;
  localparam int OPERAND_MSB = 7;
  localparam int OPERAND_LSB = 0;

endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if
// Instruction issue bus from the sequencer to the execution unit.
//   opcode  : instruction opcode (NOP between issues)
//   operand : instruction operand, twice the opcode width
//   start   : one-cycle issue strobe
// master = sequencer (drives), slave = execution unit (receives).
interface program_sequencer_if #(
  parameter int INPUT_DATA_WIDTH = 4
);
  logic [INPUT_DATA_WIDTH-1:0]   opcode;
  logic [2*INPUT_DATA_WIDTH-1:0] operand;
  logic                          start;

  modport master (output opcode, output operand, output start);
  modport slave  (input  opcode, input  operand, input  start);
endinterface

// File: rtl/program_sequencer_spi_word_rx.sv
// spi_word_rx
// SPI mode-0 slave receiver, MSB first, 12-bit words, oversampled in the
// clk domain.
//   clk, reset      : system clock, async active-high reset
//   sclk, cs_n, mosi: raw SPI pins (asynchronous to clk)
//   cs_fall, cs_rise: one-cycle strobes on synchronized chip-select edges
//   word_valid      : one-cycle strobe, word holds a complete received word
//   word            : last complete word
// The receiver runs whenever cs_n is low; the consumer decides whether a
// word is accepted. A high cs_n discards any partial word.
module spi_word_rx
  import program_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     cs_fall,
  output logic                     cs_rise,
  output logic                     word_valid,
  output logic [SPI_WORD_BITS-1:0] word
);

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_rise;
  logic [3:0] bit_cnt;
  logic [SPI_WORD_BITS-1:0] shift;

  localparam logic [3:0] LAST_BIT = 4'(SPI_WORD_BITS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      shift      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 4'd0;
      end else if (sclk_rise) begin
        shift <= {shift[SPI_WORD_BITS-2:0], mosi_sync[1]};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= 4'd0;
          word       <= {shift[SPI_WORD_BITS-2:0], mosi_sync[1]};
          word_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer
// Loads a program over SPI into an internal memory and replays it onto the
// execution unit issue bus at one instruction per 2+GAP_CYCLES cycles.
//   clk, reset       : system clock, async active-high reset
//   sclk, cs_n, mosi : SPI slave link (mode 0, 12-bit words)
//   run              : level, requests execution
//   issue            : opcode/operand/start bus (master side)
//   pc               : address of current or last-issued instruction
//   prog_len         : number of stored words
//   running / done   : executing / halted
//   load_ovf         : sticky, a word arrived while memory was full
// Build option: define PROGRAM_LOOP_EN to wrap pc to 0 at program end and
// keep executing while run is high; otherwise the sequencer halts.
//
// state | meaning
// IDLE  | waiting for a load (cs_n fall) or run
// LOAD  | receiving words over SPI into memory
// FETCH | reading mem[pc]
// ISSUE | start strobe with fetched opcode/operand
// GAP   | NOP cycles after an issue, next-pc decision on the last one
// HALT  | program finished (or empty), done high
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ROM_ADDRESS_WIDTH = 5,
  parameter int INPUT_DATA_WIDTH  = 4,
  parameter int GAP_CYCLES        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         mosi,
  input  logic                         run,
  program_sequencer_if.master          issue,
  output logic [ROM_ADDRESS_WIDTH-1:0] pc,
  output logic [ROM_ADDRESS_WIDTH:0]   prog_len,
  output logic                         running,
  output logic                         done,
  output logic                         load_ovf
);

  localparam int DEPTH = 2 ** ROM_ADDRESS_WIDTH;
  localparam logic [ROM_ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ROM_ADDRESS_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ROM_ADDRESS_WIDTH:0]   LEN_FULL = (ROM_ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [3:0]                   GAP_LAST = 4'(GAP_CYCLES - 1);

  logic                          cs_fall, cs_rise, word_valid;
  logic [SPI_WORD_BITS-1:0]      word;
  logic [SPI_WORD_BITS-1:0]      mem [DEPTH];
  logic [ROM_ADDRESS_WIDTH-1:0]  wr_ptr;
  logic [3:0]                    gap_cnt;
  logic                          full, mem_we, last_instr;
  state_t                        state;

  spi_word_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .word_valid (word_valid),
    .word       (word)
  );

  assign full       = (prog_len == LEN_FULL);
  assign mem_we     = (state == S_LOAD) && word_valid && !full;
  assign last_instr = ({1'b0, pc} == prog_len - LEN_ONE);

  // No reset on the array: contents are meaningless until prog_len covers them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      issue.opcode  <= '0;
      issue.operand <= '0;
      issue.start   <= 1'b0;
      pc            <= '0;
      prog_len      <= '0;
      wr_ptr        <= '0;
      gap_cnt       <= '0;
      running       <= 1'b0;
      done          <= 1'b0;
      load_ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state    <= S_LOAD;
            prog_len <= '0;
            wr_ptr   <= '0;
            load_ovf <= 1'b0;
          end else if (run) begin
            if (prog_len != '0) begin
              state   <= S_FETCH;
              pc      <= '0;
              running <= 1'b1;
            end else begin
              state <= S_HALT;
              done  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            if (full) begin
              load_ovf <= 1'b1;
            end else begin
              wr_ptr   <= wr_ptr + ADDR_ONE;
              prog_len <= prog_len + LEN_ONE;
            end
          end
          if (cs_rise) state <= S_IDLE;
        end
        S_FETCH: begin
          issue.opcode  <= mem[pc][OPCODE_MSB:OPCODE_LSB];
          issue.operand <= mem[pc][OPERAND_MSB:OPERAND_LSB];
          issue.start   <= 1'b1;
          state         <= S_ISSUE;
        end
        S_ISSUE: begin
          issue.opcode <= NOP_OPCODE;
          issue.start  <= 1'b0;
          gap_cnt      <= GAP_LAST;
          state        <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (!run) begin
            state   <= S_IDLE;
            pc      <= '0;
            running <= 1'b0;
          end else if (last_instr) begin
`ifdef PROGRAM_LOOP_EN
            pc    <= '0;
            state <= S_FETCH;
`else
            state   <= S_HALT;
            running <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            pc    <= pc + ADDR_ONE;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (cs_fall) begin
            state    <= S_LOAD;
            done     <= 1'b0;
            prog_len <= '0;
            wr_ptr   <= '0;
            load_ovf <= 1'b0;
          end else if (!run) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi, run;
  logic [4:0] pc;
  logic [5:0] prog_len;
  logic       running, done, load_ovf;

  program_sequencer_if #(.INPUT_DATA_WIDTH(4)) issue_if ();

  program_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .run      (run),
    .issue    (issue_if),
    .pc       (pc),
    .prog_len (prog_len),
    .running  (running),
    .done     (done),
    .load_ovf (load_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the program as the SPI master sent it, capped at 32 words.
  logic [11:0] model_mem[$];
  bit          model_ovf;

`ifdef PROGRAM_LOOP_EN
  localparam bit LOOP_MODE = 1'b1;
`else
  localparam bit LOOP_MODE = 1'b0;
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [11:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[11-i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_load(input logic [11:0] words[$], input int partial_bits,
                          input logic [11:0] partial_word);
    model_mem.delete();
    model_ovf = 1'b0;
    cs_n = 1'b0;
    tick(4);
    foreach (words[k]) begin
      spi_bits(words[k], 12);
      if (model_mem.size() < 32) model_mem.push_back(words[k]);
      else model_ovf = 1'b1;
    end
    if (partial_bits > 0) spi_bits(partial_word, partial_bits);
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic check_load(input string name);
    checks++;
    if (prog_len !== 6'(model_mem.size()) || load_ovf !== model_ovf) begin
      errors++;
      $display("FAIL %s: prog_len=%0d load_ovf=%0b expected prog_len=%0d load_ovf=%0b",
               name, prog_len, load_ovf, model_mem.size(), model_ovf);
    end
  endtask

  // Raise run and follow the issue stream cycle by cycle: issue j is expected
  // at sample 2+4j after run is seen, with NOP and held operand in between.
  task automatic run_program(input string name);
    int len, n_instr, cycles, idx, ph;
    logic [11:0] w;
    len     = model_mem.size();
    n_instr = LOOP_MODE ? 2 * len : len;
    cycles  = 4 * n_instr + 1;
    run = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      tick(1);
      if (i >= 2 && i < cycles) begin
        ph  = (i - 2) % 4;
        idx = ((i - 2) / 4) % len;
        w   = model_mem[idx];
        checks++;
        if (ph == 0) begin
          if (issue_if.start !== 1'b1 || issue_if.opcode !== w[11:8] ||
              issue_if.operand !== w[7:0] || pc !== 5'(idx)) begin
            errors++;
            $display("FAIL %s issue %0d: start=%0b op=%h opr=%h pc=%0d expected 1 %h %h %0d",
                     name, (i - 2) / 4, issue_if.start, issue_if.opcode,
                     issue_if.operand, pc, w[11:8], w[7:0], idx);
          end
        end else begin
          if (issue_if.start !== 1'b0 || issue_if.opcode !== 4'h0 ||
              (ph != 3 && issue_if.operand !== w[7:0])) begin
            errors++;
            $display("FAIL %s gap cycle %0d: start=%0b op=%h opr=%h expected 0 0 %h",
                     name, i, issue_if.start, issue_if.opcode, issue_if.operand, w[7:0]);
          end
        end
      end
      checks++;
      if (i < cycles) begin
        if (running !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s status cycle %0d: running=%0b done=%0b expected 1 0",
                   name, i, running, done);
        end
      end else if (LOOP_MODE) begin
        if (running !== 1'b1 || done !== 1'b0 || pc !== 5'd0) begin
          errors++;
          $display("FAIL %s wrap: running=%0b done=%0b pc=%0d expected 1 0 0",
                   name, running, done, pc);
        end
      end else begin
        if (running !== 1'b0 || done !== 1'b1 || pc !== 5'(len - 1)) begin
          errors++;
          $display("FAIL %s end: running=%0b done=%0b pc=%0d expected 0 1 %0d",
                   name, running, done, pc, len - 1);
        end
      end
    end
    run = 1'b0;
    tick(5);
    checks++;
    if (running !== 1'b0 || done !== 1'b0 || issue_if.start !== 1'b0) begin
      errors++;
      $display("FAIL %s stop: running=%0b done=%0b start=%0b expected 0 0 0",
               name, running, done, issue_if.start);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (issue_if.opcode !== 4'h0 || issue_if.operand !== 8'h00 || issue_if.start !== 1'b0 ||
        pc !== 5'd0 || prog_len !== 6'd0 || running !== 1'b0 || done !== 1'b0 ||
        load_ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s: op=%h opr=%h start=%0b pc=%0d len=%0d run=%0b done=%0b ovf=%0b expected all 0",
               name, issue_if.opcode, issue_if.operand, issue_if.start, pc, prog_len,
               running, done, load_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; run = 1'b0;
    tick(3);
    check_reset_values("reset_state");
    reset = 1'b0;
    tick(2);
    check_reset_values("after_reset_release");
  endtask

  task automatic test_spec_program();
    logic [11:0] q[$];
    q = '{12'h1A5, 12'h2C3, 12'h300};
    spi_load(q, 0, 12'h000);
    check_load("spec_load");
    run_program("spec_run");
  endtask

  task automatic test_random_programs();
    logic [11:0] q[$];
    for (int t = 0; t < 3; t++) begin
      q.delete();
      for (int k = 0; k < $urandom_range(1, 8); k++) q.push_back(12'($urandom));
      spi_load(q, 0, 12'h000);
      check_load("rand_load");
      run_program("rand_run");
    end
  endtask

  task automatic test_overflow();
    logic [11:0] q[$];
    for (int k = 0; k < 33; k++) q.push_back(12'($urandom));
    spi_load(q, 0, 12'h000);
    check_load("ovf_load");
    run_program("ovf_run");
    q.delete();
    q.push_back(12'h7E1);
    spi_load(q, 0, 12'h000);
    check_load("ovf_cleared");
  endtask

  task automatic test_partial();
    logic [11:0] q[$];
    q.push_back(12'($urandom));
    spi_load(q, 7, 12'($urandom));
    check_load("partial_load");
    run_program("partial_run");
  endtask

  task automatic test_empty();
    logic [11:0] q[$];
    spi_load(q, 0, 12'h000);
    check_load("empty_load");
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (done !== 1'b1 || running !== 1'b0 || issue_if.start !== 1'b0) begin
        errors++;
        $display("FAIL empty_halt cycle %0d: done=%0b running=%0b start=%0b expected 1 0 0",
                 i, done, running, issue_if.start);
      end
    end
    run = 1'b0;
    tick(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: done=%0b expected 0", done);
    end
  endtask

  task automatic test_stop_mid();
    logic [11:0] q[$];
    for (int k = 0; k < 3; k++) q.push_back(12'($urandom));
    spi_load(q, 0, 12'h000);
    run = 1'b1;
    tick(7);
    run = 1'b0;
    tick(1);
    checks++;
    if (running !== 1'b1 || pc !== 5'd1) begin
      errors++;
      $display("FAIL stop_last_gap: running=%0b pc=%0d expected 1 1", running, pc);
    end
    tick(1);
    checks++;
    if (running !== 1'b0 || pc !== 5'd0 || done !== 1'b0 || issue_if.start !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: running=%0b pc=%0d done=%0b start=%0b expected 0 0 0 0",
               running, pc, done, issue_if.start);
    end
    tick(4);
    checks++;
    if (issue_if.start !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays_idle: start=%0b running=%0b expected 0 0",
               issue_if.start, running);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] q[$];
    for (int k = 0; k < 3; k++) q.push_back(12'($urandom) | 12'h011);
    spi_load(q, 0, 12'h000);
    run = 1'b1;
    tick(3);
    #2 reset = 1'b1;
    #1;
    check_reset_values("reset_mid_gap");
    run = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    check_reset_values("reset_mid_after");
  endtask

`ifdef PROGRAM_LOOP_EN
  task automatic test_loop();
    logic [11:0] q[$];
    q = '{12'($urandom), 12'($urandom)};
    spi_load(q, 0, 12'h000);
    run_program("loop_run");
  endtask
`endif

  initial begin
    test_reset();
    test_spec_program();
    test_random_programs();
    test_overflow();
    test_partial();
    test_empty();
    test_stop_mid();
    test_reset_mid();
`ifdef PROGRAM_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
